// File: rtl/release_arb_pkg.sv
// Shared release-channel field widths, payload struct and r_type decode used by
// the release arbiter and its helpers.
package release_arb_pkg;

  localparam int ADDR_BEAT_W  = 2;
  localparam int ADDR_BLOCK_W = 26;
  localparam int XACT_ID_W    = 6;
  localparam int R_TYPE_W     = 3;
  localparam int DATA_W       = 128;

  typedef struct packed {
    logic [ADDR_BEAT_W-1:0]  addr_beat;
    logic [ADDR_BLOCK_W-1:0] addr_block;
    logic [XACT_ID_W-1:0]    client_xact_id;
    logic                    voluntary;
    logic [R_TYPE_W-1:0]     r_type;
    logic [DATA_W-1:0]       data;
  } release_t;

  // Release types 0..2 carry a full data burst; everything else is a single beat.
  function automatic logic has_data(input logic [R_TYPE_W-1:0] r_type);
    return (r_type <= 3'd2);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first valid input after last_grant, wrapping
// modulo N; with nothing valid it points at last_grant+1.
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] chosen
);

  always_comb begin
    int unsigned idx;
    logic found;
    chosen = IDX_W'((int'(last_grant) + 1) % N);
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && valid[idx]) begin
        chosen = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/release_lock_rr_arbiter.sv
// Locking round-robin arbiter sharing one release channel between N_IN clients;
// data-carrying releases keep the grant for a whole BEATS-beat burst.
module release_lock_rr_arbiter
  import release_arb_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int BEATS  = 4,
  parameter int BEAT_W = 2,
  parameter int IDX_W  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_IN-1:0]              in_valid,
  output logic [N_IN-1:0]              in_ready,
  input  logic [ADDR_BEAT_W*N_IN-1:0]  in_addr_beat,
  input  logic [ADDR_BLOCK_W*N_IN-1:0] in_addr_block,
  input  logic [XACT_ID_W*N_IN-1:0]    in_client_xact_id,
  input  logic [N_IN-1:0]              in_voluntary,
  input  logic [R_TYPE_W*N_IN-1:0]     in_r_type,
  input  logic [DATA_W*N_IN-1:0]       in_data,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [ADDR_BEAT_W-1:0]       out_addr_beat,
  output logic [ADDR_BLOCK_W-1:0]      out_addr_block,
  output logic [XACT_ID_W-1:0]         out_client_xact_id,
  output logic                         out_voluntary,
  output logic [R_TYPE_W-1:0]          out_r_type,
  output logic [DATA_W-1:0]            out_data,
  output logic [IDX_W-1:0]             out_chosen,
  output logic                         out_locked,
  output logic [BEAT_W-1:0]            out_beat_cnt
);

  logic [IDX_W-1:0]  last_grant;
  logic              locked;
  logic [IDX_W-1:0]  lock_idx;
  logic [BEAT_W-1:0] beat_cnt;

  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  chosen;
  logic              fire;
  release_t          req [N_IN];
  release_t          sel;

  for (genvar i = 0; i < N_IN; i++) begin : g_req
    assign req[i].addr_beat      = in_addr_beat[i*ADDR_BEAT_W +: ADDR_BEAT_W];
    assign req[i].addr_block     = in_addr_block[i*ADDR_BLOCK_W +: ADDR_BLOCK_W];
    assign req[i].client_xact_id = in_client_xact_id[i*XACT_ID_W +: XACT_ID_W];
    assign req[i].voluntary      = in_voluntary[i];
    assign req[i].r_type         = in_r_type[i*R_TYPE_W +: R_TYPE_W];
    assign req[i].data           = in_data[i*DATA_W +: DATA_W];
    assign in_ready[i]           = out_ready && (chosen == IDX_W'(i));
  end

  rr_priority_pick #(
    .N     (N_IN),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid      (in_valid),
    .last_grant (last_grant),
    .chosen     (pick_idx)
  );

  // A held lock overrides arbitration so the burst owner keeps the channel.
  assign chosen = locked ? lock_idx : pick_idx;
  assign sel    = req[chosen];

  assign out_valid          = in_valid[chosen];
  assign out_addr_beat      = sel.addr_beat;
  assign out_addr_block     = sel.addr_block;
  assign out_client_xact_id = sel.client_xact_id;
  assign out_voluntary      = sel.voluntary;
  assign out_r_type         = sel.r_type;
  assign out_data           = sel.data;
  assign out_chosen         = chosen;
  assign out_locked         = locked;
  assign out_beat_cnt       = beat_cnt;

  assign fire = out_valid && out_ready;

  // beat_cnt wraps naturally because BEATS is 2**BEAT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDX_W'(N_IN - 1);
      locked     <= 1'b0;
      lock_idx   <= '0;
      beat_cnt   <= '0;
    end else if (fire) begin
      last_grant <= chosen;
      if (has_data(sel.r_type)) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (beat_cnt == BEAT_W'(BEATS - 1)) begin
          locked <= 1'b0;
        end else begin
          locked   <= 1'b1;
          lock_idx <= chosen;
        end
      end
    end
  end

endmodule

// File: tb/tb_release_lock_rr_arbiter.sv
// Directed table-driven bench for release_lock_rr_arbiter plus a hand-written
// burst-exclusion sequence.
module tb_release_lock_rr_arbiter;
  import release_arb_pkg::*;

  localparam int N_IN = 4;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [11:0] rtypes;
    logic        oready;
    logic [1:0]  exp_chosen;
    logic        exp_valid;
    logic        exp_locked;
    logic [1:0]  exp_beat;
    logic [3:0]  exp_ready;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     in_valid;
  logic [3:0]     in_ready;
  logic [7:0]     in_addr_beat;
  logic [103:0]   in_addr_block;
  logic [23:0]    in_client_xact_id;
  logic [3:0]     in_voluntary;
  logic [11:0]    in_r_type;
  logic [511:0]   in_data;
  logic           out_ready;
  logic           out_valid;
  logic [1:0]     out_addr_beat;
  logic [25:0]    out_addr_block;
  logic [5:0]     out_client_xact_id;
  logic           out_voluntary;
  logic [2:0]     out_r_type;
  logic [127:0]   out_data;
  logic [1:0]     out_chosen;
  logic           out_locked;
  logic [1:0]     out_beat_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  vec_t vecs[$];

  release_lock_rr_arbiter #(.N_IN(4), .BEATS(4), .BEAT_W(2), .IDX_W(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_addr_beat       (in_addr_beat),
    .in_addr_block      (in_addr_block),
    .in_client_xact_id  (in_client_xact_id),
    .in_voluntary       (in_voluntary),
    .in_r_type          (in_r_type),
    .in_data            (in_data),
    .out_ready          (out_ready),
    .out_valid          (out_valid),
    .out_addr_beat      (out_addr_beat),
    .out_addr_block     (out_addr_block),
    .out_client_xact_id (out_client_xact_id),
    .out_voluntary      (out_voluntary),
    .out_r_type         (out_r_type),
    .out_data           (out_data),
    .out_chosen         (out_chosen),
    .out_locked         (out_locked),
    .out_beat_cnt       (out_beat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] data_of(input int i);
    logic [31:0] w;
    w = 32'hA5A50000 | i;
    return {w, ~w, w ^ 32'h0F0F0F0F, w + 32'd7};
  endfunction

  function automatic logic [37:0] fields_of(input int i, input logic [11:0] rtypes);
    logic [1:0]  ab;
    logic [25:0] blk;
    logic [5:0]  xid;
    ab  = 2'(i);
    blk = 26'h100 + 26'(i);
    xid = 6'(i * 3 + 1);
    return {ab, blk, xid, i[0], rtypes[3*i +: 3]};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [11:0] rt,
                              input logic ordy, input logic [1:0] ch, input logic val,
                              input logic lk, input logic [1:0] bc, input logic [3:0] rdy);
    vec_t r;
    r.rst = rst; r.valid = v; r.rtypes = rt; r.oready = ordy;
    r.exp_chosen = ch; r.exp_valid = val; r.exp_locked = lk;
    r.exp_beat = bc; r.exp_ready = rdy;
    return r;
  endfunction

  task automatic check(input string name, input int row, input logic [127:0] got,
                       input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL row %0d %s: got %0h expected %0h", row, name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic [3:0] v, input logic [11:0] rt,
                                input logic ordy);
    @(negedge clk);
    reset     = rst;
    in_valid  = v;
    in_r_type = rt;
    out_ready = ordy;
    #1;
  endtask

  task automatic check_output(input int row, input vec_t e);
    int c;
    c = int'(e.exp_chosen);
    check("chosen", row, 128'(out_chosen), 128'(e.exp_chosen));
    check("out_valid", row, 128'(out_valid), 128'(e.exp_valid));
    check("locked", row, 128'(out_locked), 128'(e.exp_locked));
    check("beat_cnt", row, 128'(out_beat_cnt), 128'(e.exp_beat));
    check("in_ready", row, 128'(in_ready), 128'(e.exp_ready));
    check("fields", row,
          128'({out_addr_beat, out_addr_block, out_client_xact_id, out_voluntary, out_r_type}),
          128'(fields_of(c, e.rtypes)));
    check("data", row, out_data, data_of(c));
  endtask

  initial begin
    for (int i = 0; i < N_IN; i++) begin
      in_addr_beat[2*i +: 2]        = 2'(i);
      in_addr_block[26*i +: 26]     = 26'h100 + 26'(i);
      in_client_xact_id[6*i +: 6]   = 6'(i * 3 + 1);
      in_voluntary[i]               = i[0];
      in_data[128*i +: 128]         = data_of(i);
    end
    reset = 1'b1; in_valid = '0; in_r_type = 12'o3333; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    vecs.push_back(mk(0, 4'b0000, 12'o3333, 1, 0, 0, 0, 0, 4'b0001));
    // round robin over single-beat releases
    vecs.push_back(mk(0, 4'b1111, 12'o3333, 1, 0, 1, 0, 0, 4'b0001));
    vecs.push_back(mk(0, 4'b1111, 12'o3333, 1, 1, 1, 0, 0, 4'b0010));
    vecs.push_back(mk(0, 4'b1111, 12'o3333, 1, 2, 1, 0, 0, 4'b0100));
    vecs.push_back(mk(0, 4'b1111, 12'o3333, 1, 3, 1, 0, 0, 4'b1000));
    vecs.push_back(mk(0, 4'b1111, 12'o3333, 1, 0, 1, 0, 0, 4'b0001));
    // burst from input 2 while input 1 waits
    vecs.push_back(mk(0, 4'b0010, 12'o3333, 1, 1, 1, 0, 0, 4'b0010));
    vecs.push_back(mk(0, 4'b0110, 12'o3033, 1, 2, 1, 0, 0, 4'b0100));
    vecs.push_back(mk(0, 4'b0110, 12'o3033, 1, 2, 1, 1, 1, 4'b0100));
    vecs.push_back(mk(0, 4'b0110, 12'o3033, 1, 2, 1, 1, 2, 4'b0100));
    vecs.push_back(mk(0, 4'b0110, 12'o3033, 1, 2, 1, 1, 3, 4'b0100));
    vecs.push_back(mk(0, 4'b0110, 12'o3033, 1, 1, 1, 0, 0, 4'b0010));
    // lock on input 1, then its valid drops while input 0 requests
    vecs.push_back(mk(0, 4'b0010, 12'o3313, 1, 1, 1, 0, 0, 4'b0010));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 4'b0001, 12'o3313, 1, 1, 0, 1, 1, 4'b0010));
    vecs.push_back(mk(0, 4'b0011, 12'o3313, 1, 1, 1, 1, 1, 4'b0010));
    // downstream stall during beat 2
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 4'b0011, 12'o3313, 0, 1, 1, 1, 2, 4'b0000));
    vecs.push_back(mk(0, 4'b0011, 12'o3313, 1, 1, 1, 1, 2, 4'b0010));
    vecs.push_back(mk(0, 4'b0011, 12'o3313, 1, 1, 1, 1, 3, 4'b0010));
    vecs.push_back(mk(0, 4'b0011, 12'o3313, 1, 0, 1, 0, 0, 4'b0001));
    // reset mid-burst on input 3
    vecs.push_back(mk(0, 4'b1000, 12'o2333, 1, 3, 1, 0, 0, 4'b1000));
    vecs.push_back(mk(0, 4'b1000, 12'o2333, 1, 3, 1, 1, 1, 4'b1000));
    vecs.push_back(mk(1, 4'b1000, 12'o2333, 1, 3, 1, 1, 2, 4'b1000));
    vecs.push_back(mk(0, 4'b1001, 12'o2333, 1, 0, 1, 0, 0, 4'b0001));
    // wrap-around regrant of input 3, single-beat r_type 4, idle pointer
    vecs.push_back(mk(0, 4'b1000, 12'o3333, 1, 3, 1, 0, 0, 4'b1000));
    vecs.push_back(mk(0, 4'b1000, 12'o3333, 1, 3, 1, 0, 0, 4'b1000));
    vecs.push_back(mk(0, 4'b0100, 12'o3433, 1, 2, 1, 0, 0, 4'b0100));
    vecs.push_back(mk(0, 4'b0000, 12'o3333, 1, 3, 0, 0, 0, 4'b1000));

    foreach (vecs[r]) begin
      apply_stimulus(vecs[r].rst, vecs[r].valid, vecs[r].rtypes, vecs[r].oready);
      check_output(r, vecs[r]);
    end

    // Input 0 burst must exclude input 1 for exactly four beats.
    for (int b = 0; b < 4; b++) begin
      apply_stimulus(1'b0, 4'b0011, 12'o3330, 1'b1);
      check("burst_chosen", 100 + b, 128'(out_chosen), 128'd0);
      check("burst_beat", 100 + b, 128'(out_beat_cnt), 128'(b));
      check("burst_ready1", 100 + b, 128'(in_ready[1]), 128'd0);
    end
    apply_stimulus(1'b0, 4'b0011, 12'o3330, 1'b1);
    check("after_burst_chosen", 104, 128'(out_chosen), 128'd1);
    check("after_burst_locked", 104, 128'(out_locked), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
